pc_sequencer: RTL and testbench

//  Parametrised program-counter register and next-PC selector for the CPU fetch stage.

---
 rtl/pc_sequencer.sv | 143 ++++++++++++++
 tb/tb_pc_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with prioritised next-PC selection (stall > ret > call > jump > branch > sequential).
// Define PC_RAS_EN to build the circular return-address stack that predicts return targets.
module pc_sequencer #(
   parameter int N         = 9,
   parameter int STEP      = 1,
   parameter int RESET_PC  = 0,
   parameter int RAS_DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_stall,
   input  logic         i_branch_taken,
   input  logic [N-1:0] i_branch_target,
   input  logic         i_jump,
   input  logic         i_call,
   input  logic [N-1:0] i_jump_target,
   input  logic         i_ret,
   output logic [N-1:0] o_pc,
   output logic [N-1:0] o_pc_plus,
   output logic         o_ras_empty,
   output logic         o_ras_full,
   output logic         o_ras_err
);

   localparam logic [N-1:0] STEP_V  = N'(STEP);
   localparam logic [N-1:0] RESET_V = N'(RESET_PC);

   logic [N-1:0] pc_q, pc_d;
   logic [N-1:0] pc_plus_s;

   assign pc_plus_s = pc_q + STEP_V;
   assign o_pc_plus = pc_plus_s;
   assign o_pc      = pc_q;

`ifdef PC_RAS_EN
   localparam int PW = $clog2(RAS_DEPTH);
   localparam logic [PW:0] DEPTH_V = (PW+1)'(RAS_DEPTH);

   logic [N-1:0]  ras_mem_q [RAS_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW:0]   cnt_q, cnt_d;
   logic          err_q, err_d;
   logic          push_s;
   logic [PW-1:0] top_idx_s;

   // wr_ptr points at the next free slot; the top entry sits just below it.
   assign top_idx_s = wr_ptr_q - PW'(1);

   // Next-PC selection and stack bookkeeping.
   always_comb begin
      pc_d     = pc_plus_s;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      err_d    = 1'b0;
      push_s   = 1'b0;
      if (i_stall) begin
         pc_d = pc_q;
      end else if (i_ret) begin
         if (cnt_q != '0) begin
            pc_d     = ras_mem_q[top_idx_s];
            wr_ptr_d = top_idx_s;
            cnt_d    = cnt_q - (PW+1)'(1);
         end else begin
            err_d = 1'b1;
         end
      end else if (i_call) begin
         pc_d     = i_jump_target;
         push_s   = 1'b1;
         wr_ptr_d = wr_ptr_q + PW'(1);
         // A push while full overwrites the oldest slot, so the count saturates.
         if (cnt_q != DEPTH_V) begin
            cnt_d = cnt_q + (PW+1)'(1);
         end else begin
            cnt_d = cnt_q;
         end
      end else if (i_jump) begin
         pc_d = i_jump_target;
      end else if (i_branch_taken) begin
         pc_d = i_branch_target;
      end else begin
         pc_d = pc_plus_s;
      end
   end

   // PC and stack control registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q     <= RESET_V;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end

   // Stack storage needs no reset: the count alone defines which entries are valid.
   always_ff @(posedge clk) begin
      if (push_s) begin
         ras_mem_q[wr_ptr_q] <= pc_plus_s;
      end
   end

   assign o_ras_empty = (cnt_q == '0);
   assign o_ras_full  = (cnt_q == DEPTH_V);
   assign o_ras_err   = err_q;
`else
   logic ras_unused_s;

   assign ras_unused_s = i_ret | (RAS_DEPTH < 2);

   // Without a stack, call degrades to jump and ret is ignored.
   always_comb begin
      pc_d = pc_plus_s;
      if (i_stall) begin
         pc_d = pc_q;
      end else if (i_call || i_jump) begin
         pc_d = i_jump_target;
      end else if (i_branch_taken) begin
         pc_d = i_branch_target;
      end else begin
         pc_d = pc_plus_s;
      end
   end

   // PC register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= RESET_V;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign o_ras_empty = 1'b1;
   assign o_ras_full  = 1'b0;
   assign o_ras_err   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with default parameters; RAS checks follow PC_RAS_EN.
module tb_pc_sequencer;

   localparam int N = 9;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         i_stall, i_branch_taken, i_jump, i_call, i_ret;
   logic [N-1:0] i_branch_target, i_jump_target;
   logic [N-1:0] o_pc, o_pc_plus;
   logic         o_ras_empty, o_ras_full, o_ras_err;

   int n_checks = 0;
   int n_pass   = 0;

   pc_sequencer #(.N(N), .STEP(1), .RESET_PC(0), .RAS_DEPTH(4)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_stall         (i_stall),
      .i_branch_taken  (i_branch_taken),
      .i_branch_target (i_branch_target),
      .i_jump          (i_jump),
      .i_call          (i_call),
      .i_jump_target   (i_jump_target),
      .i_ret           (i_ret),
      .o_pc            (o_pc),
      .o_pc_plus       (o_pc_plus),
      .o_ras_empty     (o_ras_empty),
      .o_ras_full      (o_ras_full),
      .o_ras_err       (o_ras_err)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      i_stall = 1'b0; i_branch_taken = 1'b0; i_jump = 1'b0; i_call = 1'b0; i_ret = 1'b0;
      i_branch_target = '0; i_jump_target = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_jump(input logic [N-1:0] t);
      idle(); i_jump = 1'b1; i_jump_target = t;
      step();
      idle();
   endtask

   task automatic do_call(input logic [N-1:0] t);
      idle(); i_call = 1'b1; i_jump_target = t;
      step();
      idle();
   endtask

   task automatic do_ret();
      idle(); i_ret = 1'b1;
      step();
      idle();
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      #12;
      chk_eq("rst_pc", o_pc, 0);
      chk_eq("rst_pc_plus", o_pc_plus, 1);
      chk_eq("rst_empty", o_ras_empty, 1);
      chk_eq("rst_full", o_ras_full, 0);
      chk_eq("rst_err", o_ras_err, 0);
      step();
      rst_n = 1'b1;
      chk_eq("rel_pc0", o_pc, 0);
      step(); chk_eq("seq_pc1", o_pc, 1);
      step(); chk_eq("seq_pc2", o_pc, 2);
      step(); chk_eq("seq_pc3", o_pc, 3);
      // Asynchronous reset lands between edges.
      #2 rst_n = 1'b0;
      #1 chk_eq("async_rst_pc", o_pc, 0);
      step();
      rst_n = 1'b1;

      do_jump(9'd510);
      chk_eq("jump_510", o_pc, 510);
      step(); chk_eq("wrap_511", o_pc, 511);
      chk_eq("plus_wrap", o_pc_plus, 0);
      step(); chk_eq("wrap_0", o_pc, 0);
      step(); chk_eq("wrap_1", o_pc, 1);
      i_stall = 1'b1; i_jump = 1'b1; i_jump_target = 9'h0AA; i_ret = 1'b1;
      step(); chk_eq("stall_1", o_pc, 1);
      chk_eq("stall_no_err", o_ras_err, 0);
      step(); chk_eq("stall_2", o_pc, 1);
      idle();

      i_branch_taken = 1'b1; i_branch_target = 9'h040; i_jump = 1'b1; i_jump_target = 9'h080;
      step(); idle();
      chk_eq("jump_over_branch", o_pc, 9'h080);
      i_branch_taken = 1'b1; i_branch_target = 9'h040;
      step(); idle();
      chk_eq("branch_alone", o_pc, 9'h040);

`ifdef PC_RAS_EN
      do_jump(9'd5);
      do_call(9'h100);
      chk_eq("call_pc", o_pc, 9'h100);
      chk_eq("call_nonempty", o_ras_empty, 0);
      do_ret();
      chk_eq("ret_pc", o_pc, 6);
      chk_eq("ret_empty", o_ras_empty, 1);

      do_jump(9'd10);
      do_call(9'd20);
      do_call(9'd30);
      do_call(9'd40);
      chk_eq("three_not_full", o_ras_full, 0);
      do_call(9'd50);
      chk_eq("four_full", o_ras_full, 1);
      do_call(9'h1F0);
      chk_eq("five_full", o_ras_full, 1);
      chk_eq("five_pc", o_pc, 9'h1F0);
      do_ret(); chk_eq("ret1", o_pc, 51);
      chk_eq("ret1_not_full", o_ras_full, 0);
      do_ret(); chk_eq("ret2", o_pc, 41);
      do_ret(); chk_eq("ret3", o_pc, 31);
      do_ret(); chk_eq("ret4", o_pc, 21);
      chk_eq("ret4_empty", o_ras_empty, 1);
      chk_eq("ret4_no_err", o_ras_err, 0);
      do_ret(); chk_eq("ret5_pc", o_pc, 22);
      chk_eq("ret5_err", o_ras_err, 1);
      step(); chk_eq("err_clears", o_ras_err, 0);
      chk_eq("after_err_pc", o_pc, 23);

      do_call(9'h100);
      chk_eq("call_b_pc", o_pc, 9'h100);
      i_ret = 1'b1; i_call = 1'b1; i_jump_target = 9'h150;
      step(); idle();
      chk_eq("ret_over_call_pc", o_pc, 24);
      chk_eq("ret_over_call_empty", o_ras_empty, 1);
`else
      do_jump(9'd5);
      do_call(9'h100);
      chk_eq("nras_call_pc", o_pc, 9'h100);
      do_ret();
      chk_eq("nras_ret_pc", o_pc, 9'h101);
      chk_eq("nras_empty", o_ras_empty, 1);
      chk_eq("nras_full", o_ras_full, 0);
      chk_eq("nras_err", o_ras_err, 0);
      i_ret = 1'b1; i_branch_taken = 1'b1; i_branch_target = 9'h033;
      step(); idle();
      chk_eq("nras_ret_branch", o_pc, 9'h033);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
